// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: start request, operands,
// registered result and the busy/done status pair.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start_i;
    logic [WIDTH-1:0] A_i;
    logic [WIDTH-1:0] B_i;
    logic [WIDTH-1:0] Diff_o;
    logic             Bout_o;
    logic             Ovf_o;
    logic             busy_o;
    logic             done_o;

    modport slave (
        input  start_i, A_i, B_i,
        output Diff_o, Bout_o, Ovf_o, busy_o, done_o
    );

    modport master (
        output start_i, A_i, B_i,
        input  Diff_o, Bout_o, Ovf_o, busy_o, done_o
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A-B, LSB first, through one full-subtractor cell and a registered borrow.
// Latency WIDTH edges from accepted start to done_o; start_i is ignored unless IDLE (no queueing).
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    serial_subtractor_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, diff_sh, diff_q;
    logic [CNT_W-1:0] count;
    logic             borrow, bout_q, ovf_q;
    logic             a, b, d, bout, last, accept;

    assign a      = a_sh[0];
    assign b      = b_sh[0];
    assign d      = a ^ b ^ borrow;
    assign bout   = (~a & b) | (~(a ^ b) & borrow);
    assign last   = (state == RUN) && (count == CNT_W'(WIDTH - 1));
    assign accept = (state == IDLE) && bus.start_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start_i) state_nxt = RUN;
            RUN:     if (last)        state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            diff_q  <= '0;
            count   <= '0;
            borrow  <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_sh    <= bus.A_i;
            b_sh    <= bus.B_i;
            diff_sh <= '0;
            diff_q  <= '0;
            count   <= '0;
            borrow  <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state == RUN) begin
            diff_sh <= {d, diff_sh[WIDTH-1:1]};
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            borrow  <= bout;
            count   <= count + 1'b1;
            // On the last bit a/b are the operand sign bits and d is the result sign.
            if (last) begin
                diff_q <= {d, diff_sh[WIDTH-1:1]};
                bout_q <= bout;
                ovf_q  <= (a != b) && (d != a);
            end
        end
    end

    assign bus.Diff_o = diff_q;
    assign bus.Bout_o = bout_q;
    assign bus.Ovf_o  = ovf_q;
    assign bus.busy_o = (state == RUN);
    assign bus.done_o = (state == DONE);
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): scoreboard of expected results,
// plus per-scenario latency, busy-length, start-spacing and reset-abort checks.
module tb_serial_subtractor;
    typedef struct packed {
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    res_t sb[$];

    serial_subtractor_if #(.WIDTH(8)) bus ();

    serial_subtractor #(.WIDTH(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b);
        res_t r;
        r.diff = a - b;
        r.bout = (a < b);
        r.ovf  = (a[7] != b[7]) && (r.diff[7] != a[7]);
        return r;
    endfunction

    // Scoreboard side: every done_o pulse pops one expected result.
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (bus.busy_o && bus.done_o) begin
                bad++;
                $display("FAIL busy_done_overlap: busy=%0b done=%0b, required not both high", bus.busy_o, bus.done_o);
            end
            if (bus.done_o) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done: done_o pulsed with no outstanding operation");
                end else begin
                    res_t r;
                    r = sb.pop_front();
                    if ({bus.Diff_o, bus.Bout_o, bus.Ovf_o} !== r) begin
                        bad++;
                        $display("FAIL result: got diff=%h bout=%b ovf=%b, required diff=%h bout=%b ovf=%b",
                                 bus.Diff_o, bus.Bout_o, bus.Ovf_o, r.diff, r.bout, r.ovf);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((bus.busy_o || bus.done_o) && n < 30) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.busy_o || bus.done_o) begin
            bad++;
            $display("FAIL wait_idle: busy=%0b done=%0b, required idle within 30 cycles", bus.busy_o, bus.done_o);
        end
    endtask

    task automatic test_reset();
        bus.start_i = 1'b0;
        bus.A_i     = 8'h00;
        bus.B_i     = 8'h00;
        rst         = 1'b1;
        #23;
        total++;
        if ({bus.Diff_o, bus.Bout_o, bus.Ovf_o, bus.busy_o, bus.done_o} !== 12'h000) begin
            bad++;
            $display("FAIL reset_state: diff=%h bout=%b ovf=%b busy=%b done=%b, required all 0",
                     bus.Diff_o, bus.Bout_o, bus.Ovf_o, bus.busy_o, bus.done_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_op(input logic [7:0] a, input logic [7:0] b);
        res_t exp_r;
        int   busy_cnt = 0;
        int   done_at  = 0;
        exp_r = model(a, b);
        wait_idle();
        bus.A_i     = a;
        bus.B_i     = b;
        bus.start_i = 1'b1;
        sb.push_back(exp_r);
        for (int i = 1; i <= 20 && done_at == 0; i++) begin
            @(negedge clk);
            if (i == 1) bus.start_i = 1'b0;
            if (bus.busy_o) busy_cnt++;
            if (bus.done_o) done_at = i;
        end
        total++;
        if (done_at != 9) begin
            bad++;
            $display("FAIL latency %h-%h: done seen in cycle %0d (0=never), required 9", a, b, done_at);
        end
        total++;
        if (busy_cnt != 8) begin
            bad++;
            $display("FAIL busy_len %h-%h: busy for %0d cycles, required 8", a, b, busy_cnt);
        end
        @(negedge clk);
        total++;
        if ({bus.Diff_o, bus.Bout_o, bus.Ovf_o, bus.done_o} !== {exp_r, 1'b0}) begin
            bad++;
            $display("FAIL hold %h-%h: diff=%h bout=%b ovf=%b done=%b, required diff=%h bout=%b ovf=%b done=0",
                     a, b, bus.Diff_o, bus.Bout_o, bus.Ovf_o, bus.done_o, exp_r.diff, exp_r.bout, exp_r.ovf);
        end
    endtask

    task automatic test_back_to_back();
        int  first  = 0;
        int  second = 0;
        logic prev  = 1'b0;
        wait_idle();
        bus.A_i     = 8'h5A;
        bus.B_i     = 8'h5A;
        bus.start_i = 1'b1;
        sb.push_back(model(8'h5A, 8'h5A));
        sb.push_back(model(8'h00, 8'h00));
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (bus.busy_o && !prev) begin
                if (first == 0) begin
                    first   = i;
                    bus.A_i = 8'h00;
                    bus.B_i = 8'h00;
                end else if (second == 0) begin
                    second      = i;
                    bus.start_i = 1'b0;
                end
            end
            prev = bus.busy_o;
        end
        bus.start_i = 1'b0;
        total++;
        if (first != 1) begin
            bad++;
            $display("FAIL b2b_first: busy rose in cycle %0d, required 1", first);
        end
        total++;
        if (second - first != 10) begin
            bad++;
            $display("FAIL b2b_spacing: start spacing %0d cycles, required 10", second - first);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL b2b_drain: %0d results outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        wait_idle();
        bus.A_i     = 8'h10;
        bus.B_i     = 8'h01;
        bus.start_i = 1'b1;
        sb.push_back(model(8'h10, 8'h01));
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) bus.start_i = 1'b0;
            if (i == 3) begin
                bus.start_i = 1'b1;
                bus.A_i     = 8'hFF;
                bus.B_i     = 8'hFF;
            end
            if (i == 4) bus.start_i = 1'b0;
            if (bus.done_o) dones++;
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL ignore_dones: %0d done pulses, required 1", dones);
        end
        total++;
        if (bus.Diff_o !== 8'h0F) begin
            bad++;
            $display("FAIL ignore_result: diff=%h, required 0f", bus.Diff_o);
        end
    endtask

    task automatic test_reset_mid();
        int   dones = 0;
        logic busy_before;
        wait_idle();
        bus.A_i     = 8'h35;
        bus.B_i     = 8'h12;
        bus.start_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) bus.start_i = 1'b0;
        end
        busy_before = bus.busy_o;
        #2 rst = 1'b1;
        #1;
        total++;
        if (busy_before !== 1'b1) begin
            bad++;
            $display("FAIL abort_busy_before: busy=%b before reset, required 1", busy_before);
        end
        total++;
        if ({bus.Diff_o, bus.Bout_o, bus.Ovf_o, bus.busy_o, bus.done_o} !== 12'h000) begin
            bad++;
            $display("FAIL abort_outputs: diff=%h bout=%b ovf=%b busy=%b done=%b, required all 0",
                     bus.Diff_o, bus.Bout_o, bus.Ovf_o, bus.busy_o, bus.done_o);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.done_o) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL abort_no_done: %0d done pulses after abort, required 0", dones);
        end
        test_op(8'h35, 8'h12);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_op(8'h35, 8'h12);
        test_op(8'h12, 8'h35);
        test_op(8'h80, 8'h01);
        test_op(8'h7F, 8'hFF);
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL final_drain: %0d results outstanding, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
